// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four valid/ready producers sharing one consumer.
// Grant is held for a whole packet, or until MAX_BEATS beats have moved.
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [3:0]          grant,
  output logic [1:0]          sel,
  output logic                busy
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       xfer;

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) winner = idx;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_data  = in_data[sel_q*DATA_W +: DATA_W];
  assign out_valid = busy & in_valid[sel_q];
  assign out_last  = busy & (in_last[sel_q] | (beat_cnt_q == LAST_BEAT));
  assign in_ready  = grant_q & {4{out_ready}};
  assign xfer      = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          state_d    = BUSY;
          grant_d    = 4'b0001 << winner;
          sel_d      = winner;
          beat_cnt_d = 8'd0;
        end
      end
      BUSY: begin
        if (xfer && out_last) begin
          // sel is kept so the mux select holds its last value while idle.
          state_d    = IDLE;
          grant_d    = 4'b0000;
          ptr_d      = sel_q + 2'd1;
          beat_cnt_d = 8'd0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter built with a 4-beat grant limit;
// inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
module tb_mux4_rr_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid;
  logic [7:0]        d [4];
  logic [31:0]       in_data;
  logic [3:0]        in_last;
  logic [3:0]        in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_ready;
  logic [3:0]        grant;
  logic [1:0]        sel;
  logic              busy;

  int errors = 0;
  int checks = 0;

  assign in_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " grant"},    32'(grant), 32'h0);
    check({tag, " busy"},     32'(busy), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " in_ready"}, 32'(in_ready), 32'h0);
  endtask

  task automatic check_busy(input string tag, input int g, input logic [7:0] data,
                            input logic last, input logic valid);
    logic [3:0] eg;
    eg = 4'b0001 << g;
    check({tag, " grant"},     32'(grant), 32'(eg));
    check({tag, " sel"},       32'(sel), 32'(g));
    check({tag, " busy"},      32'(busy), 32'h1);
    check({tag, " out_valid"}, 32'(out_valid), 32'(valid));
    if (valid) check({tag, " out_data"}, 32'(out_data), 32'(data));
    check({tag, " out_last"},  32'(out_last), 32'(last));
    check({tag, " in_ready"},  32'(in_ready), out_ready ? 32'(eg) : 32'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'h0; in_last = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset sel", 32'(sel), 32'h0);
    rst = 1'b0;

    // All four requesting single-beat packets: 0,1,2,3,0 with a bubble each
    in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    #1; check_idle("rr pre");
    tick;
    for (int k = 0; k < 5; k++) begin
      #1; check_busy($sformatf("rr g%0d", k), k % 4, 8'hA0 + 8'(k % 4), 1'b1, 1'b1);
      tick;
      if (k == 4) in_valid = 4'h0;
      #1; check_idle($sformatf("rr bubble%0d", k));
      tick;
    end

    // ptr=1: single beat from requester 1 moves ptr to 2
    in_valid = 4'b0010; d[1] = 8'h11; in_last = 4'b0010;
    tick;
    #1; check_busy("p1", 1, 8'h11, 1'b1, 1'b1);
    tick;
    // Requester 2 three-beat packet while requester 1 waits
    in_valid = 4'b0110; in_last = 4'b0010; d[2] = 8'h21; d[1] = 8'h15;
    #1; check_idle("p2 pre");
    tick;
    #1; check_busy("p2 b1", 2, 8'h21, 1'b0, 1'b1);
    tick;
    d[2] = 8'h22;
    #1; check_busy("p2 b2", 2, 8'h22, 1'b0, 1'b1);
    tick;
    d[2] = 8'h23; in_last = 4'b0110;
    #1; check_busy("p2 b3", 2, 8'h23, 1'b1, 1'b1);
    tick;
    in_valid = 4'b0010;
    #1; check_idle("p2 bubble");
    tick;
    #1; check_busy("p2 r1", 1, 8'h15, 1'b1, 1'b1);
    tick;
    in_valid = 4'h0;
    tick;

    // ptr=2: requester 0 streams without last, forced release at beat 4
    in_valid = 4'b0001; in_last = 4'b0000; d[0] = 8'h01;
    tick;
    in_valid = 4'b1001; in_last = 4'b1000; d[3] = 8'h3C;
    for (int b = 1; b <= 4; b++) begin
      d[0] = 8'(b);
      #1; check_busy($sformatf("force b%0d", b), 0, 8'(b), b == 4, 1'b1);
      tick;
    end
    d[0] = 8'h05;
    #1; check_idle("force bubble");
    tick;
    #1; check_busy("force r3", 3, 8'h3C, 1'b1, 1'b1);
    tick;
    in_valid = 4'b0001;
    tick;
    #1; check_busy("force b5", 0, 8'h05, 1'b0, 1'b1);
    tick;
    d[0] = 8'h06; in_last = 4'b0001;
    #1; check_busy("force b6", 0, 8'h06, 1'b1, 1'b1);
    tick;
    in_valid = 4'h0; in_last = 4'h0;
    tick;

    // ptr=1: backpressure mid-packet; beat limit still lands on the 4th beat
    in_valid = 4'b0010; d[1] = 8'h41;
    tick;
    #1; check_busy("bp b1", 1, 8'h41, 1'b0, 1'b1);
    tick;
    d[1] = 8'h42; out_ready = 1'b0; in_valid = 4'b0110;
    for (int s = 0; s < 5; s++) begin
      #1; check_busy($sformatf("bp stall%0d", s), 1, 8'h42, 1'b0, 1'b1);
      tick;
    end
    out_ready = 1'b1;
    #1; check_busy("bp b2", 1, 8'h42, 1'b0, 1'b1);
    tick;
    d[1] = 8'h43;
    #1; check_busy("bp b3", 1, 8'h43, 1'b0, 1'b1);
    tick;
    d[1] = 8'h44;
    #1; check_busy("bp b4", 1, 8'h44, 1'b1, 1'b1);
    tick;
    in_valid = 4'h0;
    tick;

    // ptr=2: requester 1 valid bubble while requester 2 requests
    in_valid = 4'b0010; d[1] = 8'h61;
    tick;
    in_valid = 4'b0110; d[2] = 8'h77; in_last = 4'b0100;
    #1; check_busy("vb b1", 1, 8'h61, 1'b0, 1'b1);
    tick;
    in_valid = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      #1; check_busy($sformatf("vb gap%0d", s), 1, 8'h00, 1'b0, 1'b0);
      tick;
    end
    in_valid = 4'b0110; d[1] = 8'h62; in_last = 4'b0110;
    #1; check_busy("vb b2", 1, 8'h62, 1'b1, 1'b1);
    tick;
    #1; check_idle("vb bubble");
    tick;
    #1; check_busy("vb r2", 2, 8'h77, 1'b1, 1'b1);
    tick;
    in_valid = 4'h0; in_last = 4'h0;
    tick;

    // ptr=3: reset asserted mid-packet drops grant at once and clears ptr
    in_valid = 4'b0001; d[0] = 8'h90;
    tick;
    #1; check_busy("rst pre", 0, 8'h90, 1'b0, 1'b1);
    #1; rst = 1'b1;
    #1; check_idle("rst mid");
    check("rst mid sel", 32'(sel), 32'h0);
    tick;
    rst = 1'b0; in_valid = 4'b1010; d[1] = 8'hB1; in_last = 4'b0010;
    #1; check_idle("rst post");
    tick;
    #1; check_busy("rst arb", 1, 8'hB1, 1'b1, 1'b1);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one downstream channel between four upstream requesters.
- Drives the select of a 4:1 datapath mux and holds the grant for a whole packet, up to a per-grant beat limit.
- Sits between four valid/ready producers and one valid/ready consumer.
- Grant state is registered; the data path through the mux is combinational.

Parameters:
- DATA_W, 8, width of each requester's data bus and of the output data.
- MAX_BEATS, 16, maximum beats per grant before a forced release; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-requester valid; bit i is requester i.
- in_data  input  4*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  4  per-requester end-of-packet flag.
- in_ready  output  4  per-requester ready.
- out_valid  output  1  downstream valid.
- out_data  output  DATA_W  downstream data, the muxed in_data of the selected requester.
- out_last  output  1  downstream last; asserted on packet end or on forced release.
- out_ready  input  1  downstream ready.
- grant  output  4  one-hot current grant; all zeros when idle.
- sel  output  2  mux select, the encoded form of grant; holds its last value when idle.
- busy  output  1  high while in the BUSY state.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, grant=0, sel=0, priority pointer ptr=0, beat_cnt=0, busy=0.
  - All in_ready=0 and out_valid=0 combinationally.
- Reset asserted mid-packet:
  - The grant is dropped immediately; no further beats transfer.
  - The consumer sees a truncated packet; this is accepted.
- A transfer on a cycle is defined as out_valid && out_ready.
- IDLE state:
  - out_valid=0, in_ready=0.
  - If any in_valid bit is set, the winner is the first set bit searching ptr, ptr+1, ... modulo 4.
  - On that edge: grant=onehot(winner), sel=winner, beat_cnt=0, state goes to BUSY.
  - Latency from request to first possible transfer is one cycle.
- BUSY state:
  - out_valid = in_valid[sel], out_data = in_data[sel], in_ready = grant & {4{out_ready}}.
  - A non-granted requester never sees ready.
  - out_last = in_last[sel] OR (beat_cnt == MAX_BEATS-1).
  - On each transfer, beat_cnt increments.
- Release from BUSY:
  - Condition: a transfer with out_last=1.
  - On that edge: state goes to IDLE, grant=0, ptr=(sel+1) mod 4, beat_cnt=0.
  - Re-arbitration happens in IDLE on the following cycle, so there is one bubble cycle between grants.
- Forced release (beat limit reached without in_last):
  - The requester's remaining beats are presented again on its next grant.
  - in_data and in_last are not consumed; the requester sees no ready on that cycle beyond the transfer itself.
- Granted requester drops in_valid mid-packet:
  - The grant holds; out_valid goes low.
  - No timeout applies; only beats that actually transfer count toward MAX_BEATS.
- out_ready low: everything stalls and no state changes.
- in_valid changes on non-granted ports while BUSY: no effect.
- MAX_BEATS=1: every beat is a single-beat grant with out_last=1.
- beat_cnt width is 8 bits; it never wraps because release occurs at MAX_BEATS-1.
- ptr advances only on release; it does not advance on an idle cycle with no requests.

Test Plan:
- Reset sequence: assert rst mid-stream -> grant=0, busy=0, in_ready=0, out_valid=0 in the same cycle; after release, first arbitration grants the lowest requesting index starting at 0.
- All four valid with 1-beat packets (in_last=1), out_ready=1 -> grant sequence 0,1,2,3,0. Each transfer is followed by one IDLE cycle. out_data matches each requester's pattern, e.g. 0xA0..0xA3.
- Requester 2 sends a 3-beat packet (0x21, 0x22, 0x23; last on 0x23), requester 1 requests throughout -> requester 1 gets no ready until 0x23 transfers; requester 1 is granted two cycles later.
- MAX_BEATS=4, requester 0 streams 6 beats with no last, requester 3 waiting -> out_last forced on beat 4; requester 3 is granted next; requester 0 later resumes at beat 5.
- Backpressure: out_ready low for 5 cycles during a granted packet -> out_data stable, beat_cnt unchanged, no grant change, no lost or duplicated beats.
- Valid bubble: granted requester 1 drops in_valid for 3 cycles mid-packet while requester 2 requests -> grant stays 1; requester 2 is granted only after requester 1's last beat.
